// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO: pointer code conversion and default sizes.
// Pure definitions; no latency and no flow control of their own.
package fifo_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int DATA_SIZE_DEF = 8;
    localparam int OCC_W         = 2;
    localparam int PTR_MAX       = 16;

    typedef logic [PTR_MAX-1:0] ptr_wide_t;

    function automatic ptr_wide_t width_mask(input int w);
        return (ptr_wide_t'(1) << w) - ptr_wide_t'(1);
    endfunction

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b, input int w);
        return ((b >> 1) ^ b) & width_mask(w);
    endfunction

    function automatic ptr_wide_t gray2bin(input ptr_wide_t g, input int w);
        ptr_wide_t b;
        ptr_wide_t gm;
        gm = g & width_mask(w);
        b = gm;
        // Each binary bit is the XOR of all Gray bits at or above it.
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_fwft_buf.sv
// Two-entry first-word-fall-through output buffer (head + skid); capture lands in rdata next edge.
// Latency 1 edge from capture to rvalid; upstream must never capture into a full buffer (cnt==2 without deq).
module fifo_fwft_buf
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap,
    input  logic [DATA_SIZE-1:0] cap_data,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [OCC_W-1:0]     cnt
);

    logic [DATA_SIZE-1:0] skid_dat;
    logic                 skid_vld;
    logic                 deq;

    assign deq = rvalid & rready;
    assign cnt = OCC_W'(rvalid) + OCC_W'(skid_vld);

    // The head only changes when it is empty or being dequeued, so rdata holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            skid_dat <= '0;
            skid_vld <= 1'b0;
        end else if (deq) begin
            if (skid_vld) begin
                rdata    <= skid_dat;
                skid_vld <= cap;
                if (cap) begin
                    skid_dat <= cap_data;
                end
            end else begin
                rvalid <= cap;
                if (cap) begin
                    rdata <= cap_data;
                end
            end
        end else if (cap) begin
            if (!rvalid) begin
                rdata  <= cap_data;
                rvalid <= 1'b1;
            end else begin
                skid_dat <= cap_data;
                skid_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller: read pointers, empty/almost-empty/level, RAM read port, FWFT output.
// rvalid rises 3 edges after rq2_wptr leaves the read pointer; pops stop when buffer plus in-flight reach 2.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE     = ADDR_SIZE_DEF,
    parameter int DATA_SIZE     = DATA_SIZE_DEF,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic                 rmem_en,
    input  logic [DATA_SIZE-1:0] rmem_data,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDR_SIZE:0]   rlevel
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0]    rbin;
    logic [PW-1:0]    rbin_next;
    logic [PW-1:0]    rgray_next;
    logic [PW-1:0]    wbin_s;
    logic [PW-1:0]    level_next;
    ptr_wide_t        rgray_w;
    ptr_wide_t        wbin_w;
    logic             unused_hi;
    logic             inflight;
    logic [OCC_W-1:0] buf_cnt;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_after;
    logic             deq;
    logic             pop;

    assign deq       = rvalid & rready;
    assign occ       = buf_cnt + OCC_W'(inflight);
    assign occ_after = occ - OCC_W'(deq);
    assign pop       = ~rempty & (occ_after < OCC_W'(2));

    assign rmem_en = pop;
    assign raddr   = rbin[ADDR_SIZE-1:0];

    assign rbin_next  = rbin + PW'(pop);
    assign rgray_w    = bin2gray(ptr_wide_t'(rbin_next), PW);
    assign wbin_w     = gray2bin(ptr_wide_t'(rq2_wptr), PW);
    assign rgray_next = rgray_w[PW-1:0];
    assign wbin_s     = wbin_w[PW-1:0];
    assign level_next = wbin_s - rbin_next;
    assign unused_hi  = ^{rgray_w[PTR_MAX-1:PW], wbin_w[PTR_MAX-1:PW]};

    // Flags use rbin_next so a pop and a write-pointer update in the same cycle both count.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin     <= '0;
            rptr     <= '0;
            rempty   <= 1'b1;
            raempty  <= 1'b1;
            rlevel   <= '0;
            inflight <= 1'b0;
        end else begin
            rbin     <= rbin_next;
            rptr     <= rgray_next;
            rempty   <= (rgray_next == rq2_wptr);
            raempty  <= (level_next <= PW'(AEMPTY_THRESH));
            rlevel   <= level_next;
            inflight <= pop;
        end
    end

    fifo_fwft_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_buf (
        .clk      (rclk),
        .rst      (rrst),
        .cap      (inflight),
        .cap_data (rmem_data),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .cnt      (buf_cnt)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: scoreboard queues of expected RAM addresses and output words,
// drained by a negedge monitor; flags and pointers checked directly at hand-derived cycles.
module tb_fifo_read_ctrl;

    logic       rclk;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic       rmem_en;
    logic [7:0] rmem_data;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;

    fifo_read_ctrl #(
        .ADDR_SIZE     (4),
        .DATA_SIZE     (8),
        .AEMPTY_THRESH (2)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rq2_wptr  (rq2_wptr),
        .rptr      (rptr),
        .raddr     (raddr),
        .rmem_en   (rmem_en),
        .rmem_data (rmem_data),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic [7:0] mem [16];
    logic [7:0] data_q [$];
    logic [3:0] addr_q [$];
    logic [4:0] wbin;
    logic [4:0] rpos;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt, en_first, en_last;
    int xf_cnt, xf_first, xf_last;
    logic       hold_prev;
    logic [7:0] prev_dat;

    always @(posedge rclk) begin
        if (rmem_en) rmem_data <= mem[raddr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_stats();
        en_cnt = 0; en_first = 0; en_last = 0;
        xf_cnt = 0; xf_first = 0; xf_last = 0;
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            addr_q.push_back(rpos[3:0]);
            data_q.push_back(mem[rpos[3:0]]);
            rpos = rpos + 5'd1;
        end
        wbin = wbin + 5'(n);
        rq2_wptr = wbin ^ (wbin >> 1);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((data_q.size() != 0 || !rempty || rvalid) && t < 300) begin
            @(negedge rclk);
            t++;
        end
        check(name, int'(t < 300), 1);
        @(negedge rclk);
    endtask

    always @(negedge rclk) begin
        logic [7:0] exp_d;
        logic [3:0] exp_a;
        cyc++;
        if (rrst) begin
            hold_prev = 1'b0;
        end else begin
            if (rmem_en) begin
                en_cnt++;
                if (en_cnt == 1) en_first = cyc;
                en_last = cyc;
                if (addr_q.size() == 0) begin
                    check("raddr_unexpected_pop", 1, 0);
                end else begin
                    exp_a = addr_q.pop_front();
                    check("raddr", int'(raddr), int'(exp_a));
                end
            end
            if (hold_prev && rvalid) check("rdata_hold", int'(rdata), int'(prev_dat));
            if (rvalid && rready) begin
                xf_cnt++;
                if (xf_cnt == 1) xf_first = cyc;
                xf_last = cyc;
                if (data_q.size() == 0) begin
                    check("rdata_unexpected_word", 1, 0);
                end else begin
                    exp_d = data_q.pop_front();
                    check("rdata", int'(rdata), int'(exp_d));
                end
            end
            hold_prev = rvalid && !rready;
            prev_dat  = rdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 5);
        rrst = 1'b1; rready = 1'b0; rq2_wptr = 5'd0; rmem_data = 8'd0;
        wbin = 5'd0; rpos = 5'd0; hold_prev = 1'b0; prev_dat = 8'd0;
        clr_stats();

        // Reset while idle
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        check("rst_rempty", int'(rempty), 1);
        check("rst_raempty", int'(raempty), 1);
        check("rst_rvalid", int'(rvalid), 0);
        check("rst_rptr", int'(rptr), 0);
        check("rst_rlevel", int'(rlevel), 0);
        check("rst_rmem_en", int'(rmem_en), 0);
        check("rst_rdata", int'(rdata), 0);
        @(posedge rclk); #1 rrst = 1'b0;
        repeat (3) @(posedge rclk);

        // Single word: latency profile
        rready = 1'b1;
        #1 clr_stats(); push_words(1);
        @(negedge rclk);
        check("t2_rempty_T", int'(rempty), 1);
        @(negedge rclk);
        check("t2_rempty_T1", int'(rempty), 0);
        check("t2_rmem_en_T1", int'(rmem_en), 1);
        check("t2_rlevel_T1", int'(rlevel), 1);
        @(negedge rclk);
        check("t2_rempty_T2", int'(rempty), 1);
        check("t2_rptr_T2", int'(rptr), 1);
        check("t2_rvalid_T2", int'(rvalid), 0);
        @(negedge rclk);
        check("t2_rvalid_T3", int'(rvalid), 1);
        check("t2_rdata_T3", int'(rdata), int'(8'd5));
        wait_drain("t2_drain");
        check("t2_pops", en_cnt, 1);

        // Reset in the middle of a burst, with a read in flight
        @(posedge rclk); #1 push_words(6);
        repeat (3) @(posedge rclk);
        #2 rrst = 1'b1;
        #1;
        check("t1b_rempty", int'(rempty), 1);
        check("t1b_raempty", int'(raempty), 1);
        check("t1b_rvalid", int'(rvalid), 0);
        check("t1b_rptr", int'(rptr), 0);
        check("t1b_rlevel", int'(rlevel), 0);
        check("t1b_rmem_en", int'(rmem_en), 0);
        data_q.delete(); addr_q.delete();
        wbin = 5'd0; rpos = 5'd0; rq2_wptr = 5'd0;
        clr_stats();
        repeat (2) @(posedge rclk); #1 rrst = 1'b0;
        repeat (5) @(negedge rclk);
        check("t1b_post_rvalid", int'(rvalid), 0);
        check("t1b_post_rempty", int'(rempty), 1);
        check("t1b_post_xfers", xf_cnt, 0);

        // Full 16-word burst, back to back
        @(posedge rclk); #1 clr_stats(); push_words(16);
        wait_drain("t3_drain");
        check("t3_pops", en_cnt, 16);
        check("t3_pop_span", en_last - en_first + 1, 16);
        check("t3_xfers", xf_cnt, 16);
        check("t3_xfer_span", xf_last - xf_first + 1, 16);
        check("t3_rptr", int'(rptr), int'(5'b11000));
        check("t3_rempty", int'(rempty), 1);
        check("t3_rlevel", int'(rlevel), 0);

        // Backpressure with 5 words, then threshold crossing on release
        @(posedge rclk); #1 rready = 1'b0; clr_stats(); push_words(5);
        repeat (8) @(posedge rclk);
        @(negedge rclk);
        check("t4_pops", en_cnt, 2);
        check("t4_rlevel", int'(rlevel), 3);
        check("t4_raempty", int'(raempty), 0);
        check("t4_rvalid", int'(rvalid), 1);
        check("t4_rdata", int'(rdata), int'(mem[0]));
        @(posedge rclk); #1 rready = 1'b1;
        @(negedge rclk);
        check("t6_rlevel3", int'(rlevel), 3);
        check("t6_raempty_lvl3", int'(raempty), 0);
        check("t6_rmem_en", int'(rmem_en), 1);
        @(negedge rclk);
        check("t6_rlevel2", int'(rlevel), 2);
        check("t6_raempty_lvl2", int'(raempty), 1);
        wait_drain("t4_drain");
        check("t4_xfers", xf_cnt, 5);

        // Wrap of the pointer MSB: advance to rbin=30, then 4 more words
        @(posedge rclk); #1 push_words(9);
        wait_drain("t5_pre_drain");
        check("t5_rptr_30", int'(rptr), int'(5'b10001));
        @(posedge rclk); #1 clr_stats(); push_words(4);
        check("t5_wptr", int'(rq2_wptr), int'(5'b00011));
        wait_drain("t5_drain");
        check("t5_pops", en_cnt, 4);
        check("t5_rptr_2", int'(rptr), int'(5'b00011));
        check("t5_rempty", int'(rempty), 1);
        check("t5_rlevel", int'(rlevel), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
